// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Turns valid/ready commands into a single cycle of per-bit J/K drive for a
//   bank of WIDTH JK flip-flops, then reads the bank back one cycle later and
//   reports completion, the captured value and whether it matched.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_op          000 NOP, 001 LOAD, 010 CLEAR, 011 SET, 100 TOGGLE,
//                   101 INC, 110 DEC, 111 reserved
//   cmd_data        LOAD value / TOGGLE mask
//   q_fb            bank outputs
//   j, k            registered bank drive, non-zero only during APPLY
//   done            one-cycle completion pulse
//   err             readback mismatch or reserved op (valid with done)
//   result          q_fb captured at completion
//   mismatch_cnt    saturating count of completions with err
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [ERRW-1:0]  mismatch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_LOAD   = 3'b001,
    OP_CLEAR  = 3'b010,
    OP_SET    = 3'b011,
    OP_TOGGLE = 3'b100,
    OP_INC    = 3'b101,
    OP_DEC    = 3'b110,
    OP_RSV    = 3'b111
  } op_t;

  state_t           state_q;
  logic [WIDTH-1:0] j_q, k_q, exp_q, result_q;
  logic             rsv_q, done_q, err_q;
  logic [ERRW-1:0]  cnt_q;

  logic [WIDTH-1:0] j_d, k_d, exp_d;
  logic             rsv_d;
  logic             err_now;

  // Drive and expected value are derived from the q_fb snapshot taken at
  // acceptance, so later bank or command changes cannot affect them.
  always_comb begin
    j_d   = '0;
    k_d   = '0;
    exp_d = q_fb;
    rsv_d = 1'b0;
    case (op_t'(cmd_op))
      OP_NOP: ;
      OP_LOAD: begin
        j_d   = cmd_data;
        k_d   = ~cmd_data;
        exp_d = cmd_data;
      end
      OP_CLEAR: begin
        k_d   = '1;
        exp_d = '0;
      end
      OP_SET: begin
        j_d   = '1;
        exp_d = '1;
      end
      OP_TOGGLE: begin
        j_d   = cmd_data;
        k_d   = cmd_data;
        exp_d = q_fb ^ cmd_data;
      end
      // Counting is done by toggling only the bits that change.
      OP_INC: begin
        exp_d = q_fb + WIDTH'(1);
        j_d   = q_fb ^ exp_d;
        k_d   = q_fb ^ exp_d;
      end
      OP_DEC: begin
        exp_d = q_fb - WIDTH'(1);
        j_d   = q_fb ^ exp_d;
        k_d   = q_fb ^ exp_d;
      end
      default: rsv_d = 1'b1;
    endcase
  end

  assign err_now = (q_fb != exp_q) | rsv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      k_q      <= '0;
      exp_q    <= '0;
      rsv_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            j_q     <= j_d;
            k_q     <= k_d;
            exp_q   <= exp_d;
            rsv_q   <= rsv_d;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          done_q   <= 1'b1;
          result_q <= q_fb;
          err_q    <= err_now;
          if (err_now && (cnt_q != '1))
            cnt_q <= cnt_q + ERRW'(1);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign j            = j_q;
  assign k            = k_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a JK bank model closes the loop, expected
// completions are queued at acceptance and compared when done pulses.
module tb_jk_bank_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] q_fb, j, k, result;
  logic         done, err;
  logic [7:0]   mismatch_cnt;

  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         e;
    logic [7:0]   cnt;
  } exp_t;
  typedef struct {
    logic [W-1:0] jj;
    logic [W-1:0] kk;
  } jk_t;

  exp_t res_q[$];
  jk_t  jk_q[$];
  logic [7:0] exp_cnt = '0;

  int cyc = 0;
  int last_done = -1;
  bit b2b = 0;
  bit apply_pend = 0;

  jk_bank_sequencer #(.WIDTH(W), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .q_fb(q_fb), .j(j), .k(k),
    .done(done), .err(err), .result(result), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // JK flip-flop bank (plant), optionally with stuck-at-0 outputs.
  assign q_fb = bank & ~stuck;
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b10:   bank[i] <= 1'b1;
        2'b01:   bank[i] <= 1'b0;
        2'b11:   bank[i] <= ~bank[i];
        default: bank[i] <= bank[i];
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] jj,
                                           input logic [W-1:0] kk);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++)
      r[i] = (jj[i] & ~q[i]) | (~kk[i] & q[i]);
    return r;
  endfunction

  // Expected behaviour for one accepted command, from current bank state.
  task automatic push_expect(input logic [2:0] op, input logic [W-1:0] data);
    logic [W-1:0] cur, ev, jj, kk, nb;
    logic         rsv;
    exp_t e;
    jk_t  d;
    cur = q_fb;
    jj = '0; kk = '0; ev = cur; rsv = 1'b0;
    case (op)
      3'b000: ;
      3'b001: begin jj = data; kk = ~data; ev = data; end
      3'b010: begin kk = '1; ev = '0; end
      3'b011: begin jj = '1; ev = '1; end
      3'b100: begin jj = data; kk = data; ev = cur ^ data; end
      3'b101: begin ev = cur + 4'd1; jj = cur ^ ev; kk = jj; end
      3'b110: begin ev = cur - 4'd1; jj = cur ^ ev; kk = jj; end
      default: rsv = 1'b1;
    endcase
    nb    = jk_next(bank, jj, kk);
    e.res = nb & ~stuck;
    e.e   = rsv | (e.res != ev);
    if (e.e && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    e.cnt = exp_cnt;
    d.jj = jj;
    d.kk = kk;
    res_q.push_back(e);
    jk_q.push_back(d);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      apply_pend = 0;
    end else begin
      if (apply_pend) begin
        jk_t d;
        apply_pend = 0;
        if (jk_q.size() > 0) begin
          d = jk_q.pop_front();
          check("apply_j", 32'(j), 32'(d.jj));
          check("apply_k", 32'(k), 32'(d.kk));
        end
      end
      if (done) begin
        exp_t e;
        if (res_q.size() == 0) begin
          check("spurious_done", 32'(done), 0);
        end else begin
          e = res_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("err", 32'(err), 32'(e.e));
          check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
          check("jk_idle", 32'(j | k), 0);
          check("ready_at_done", 32'(cmd_ready), 1);
        end
        if (b2b) begin
          if (last_done >= 0) check("done_gap", 32'(cyc - last_done), 3);
          last_done = cyc;
        end
      end
      if (cmd_valid && cmd_ready) apply_pend = 1;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] data, input bit hold);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        push_expect(op, data);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'(ok), 1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && res_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain", res_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    #12;
    check("rst_j", 32'(j), 0);
    check("rst_k", 32'(k), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_cnt", 32'(mismatch_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_idle", 32'(cmd_ready), 1);

    // Reset asserted mid-APPLY with a LOAD in flight.
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_data = 4'h5;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("abort_apply_j", 32'(j), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("abort_j", 32'(j), 0);
    check("abort_k", 32'(k), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 0);
    check("abort_cnt", 32'(mismatch_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(cmd_ready), 1);
    repeat (5) @(posedge clk);
    #1;

    issue(3'b001, 4'hA, 0); drain();
    issue(3'b100, 4'hF, 0); drain();
    issue(3'b011, 4'h0, 0); drain();
    issue(3'b101, 4'h0, 0); drain();
    issue(3'b110, 4'h0, 0); drain();

    b2b = 1; last_done = -1;
    issue(3'b001, 4'h6, 1);
    issue(3'b101, 4'h0, 1);
    issue(3'b101, 4'h0, 1);
    issue(3'b110, 4'h0, 0);
    drain();
    b2b = 0;

    stuck = 4'h1;
    issue(3'b001, 4'h1, 0); drain();
    check("stuck_cnt", 32'(mismatch_cnt), 1);
    stuck = 4'h0;

    for (int r = 0; r < 300; r++) begin
      issue(3'b111, 4'h3, 0);
      drain();
    end
    check("sat_cnt", 32'(mismatch_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH single-bit JK flip-flop cells. Each cell has inputs j, k and output q, and updates on posedge clk.
- Converts high-level commands into one cycle of per-bit J/K drive: LOAD, CLEAR, SET, TOGGLE, INC and DEC.
- Reads the bank outputs back and checks them against the expected value, then reports done, result and error.
- Sits between a command source (valid/ready) and the flip-flop bank. The sequencer is the only driver of the bank's j/k inputs.

Parameters:
- WIDTH, 4, number of JK cells in the bank; legal range 1..32.
- ERRW, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 CLEAR, 011 SET, 100 TOGGLE, 101 INC, 110 DEC, 111 reserved.
- cmd_data  input  WIDTH  LOAD value or TOGGLE mask; ignored by all other ops.
- q_fb  input  WIDTH  q outputs of the bank, bit i from cell i.
- j  output  WIDTH  J drive to the bank, bit i to cell i.
- k  output  WIDTH  K drive to the bank, bit i to cell i.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  valid only with done; 1 = readback mismatch or reserved op.
- result  output  WIDTH  q_fb captured at completion; held until the next done.
- mismatch_cnt  output  ERRW  count of completions with err=1; saturates at all-ones.

Behaviour:
- Reset is asynchronous and immediate, and may occur mid-operation. On reset: state=IDLE, j=0, k=0, done=0, err=0, result=0, mismatch_cnt=0. Any in-flight command is abandoned and is not reported.
- FSM states: IDLE, APPLY, CHECK.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op and data, snapshot q_fb into cur, compute exp, and go to APPLY.
- APPLY:
  - Lasts exactly 1 cycle; cmd_ready=0.
  - j/k are registered outputs, valid throughout APPLY; the bank updates on the edge that ends APPLY.
  - Next state is CHECK.
- CHECK:
  - Lasts 1 cycle; cmd_ready=0; j=k=0.
  - Compare q_fb with exp, then go to IDLE.
  - On that edge: done<=1, result<=q_fb, err<=(q_fb!=exp)|reserved, and mismatch_cnt increments if err (saturating).
- j=k=0 in every state except APPLY, so the bank holds.
- Per-op drive during APPLY:
  - NOP: j=0, k=0; exp=cur.
  - LOAD: j=data, k=~data; exp=data.
  - CLEAR: j=0, k=all-ones; exp=0.
  - SET: j=all-ones, k=0; exp=all-ones.
  - TOGGLE: j=k=data; exp=cur^data.
  - INC: exp=(cur+1) mod 2^WIDTH; j=k=cur^exp (toggle only the changing bits).
  - DEC: exp=(cur-1) mod 2^WIDTH; j=k=cur^exp.
  - Reserved 111: drive as NOP; err=1 on completion regardless of readback.
- Wrap-around: INC of all-ones gives 0; DEC of 0 gives all-ones.
- Latency: command accepted at edge T → APPLY in cycle T+1 → CHECK in T+2 → done high for cycle T+3 only.
- Back-to-back: done and cmd_ready are both 1 in the completion cycle, so a new command may be accepted then. Maximum throughput is one command per 3 cycles.
- cmd_data/cmd_op are sampled only at acceptance; later changes have no effect.
- done defaults to 0 every cycle except as above. err is meaningful only when done=1 and holds its last value otherwise.

Test Plan:
- WIDTH=4; assert rst mid-APPLY with a LOAD pending → j,k,done,result,mismatch_cnt are 0 immediately (same cycle); cmd_ready=1 after release; no done for the aborted command.
- LOAD 4'hA, then TOGGLE mask 4'hF → first completion: result=4'hA, err=0, with j=1010/k=0101 during APPLY; second: result=4'h5, err=0.
- SET, then INC → j=k=4'hF during APPLY; result=4'h0 (wrap), err=0. Then DEC → result=4'hF, err=0.
- LOAD 4'h6, INC, INC, DEC issued back-to-back with cmd_valid held high → done every 3rd cycle, results 6,7,8,7; j=k=4'hF on the 7→8 step.
- Bench model forces q_fb bit0 stuck at 0, then LOAD 4'h1 → done with err=1, result=4'h0, mismatch_cnt=1.
- Reserved op 111, repeated 300 times with ERRW=8 → each completion err=1, j=k=0; mismatch_cnt saturates at 255.
